// File: rtl/matmul_seq_ctrl.sv
// Sequencer for an NxN signed matrix multiply C = A*B.
// Rows i and i+1 of A are read in parallel against column j of B, so two
// results come out of each pass over k. RAM A's address and write inputs
// go straight through from the host while the sequencer is idle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | host owns RAM A; waiting for start
// S_RUN   | issue reads for k = 0..N-1 (A rows i,i+1 / B column j)
// S_DRAIN | wait RD_LAT cycles for the last read data to reach the MACs
// S_WR0   | write MAC0 result to C[i][j]
// S_WR1   | write MAC1 result to C[i+1][j], advance the (i,j) pair
// S_FIN   | last pair written; pulse done on the way back to idle
module matmul_seq_ctrl #(
    parameter int N      = 8,
    parameter int AW     = 6,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          host_wr,
    input  logic [AW-1:0] host_addr,
    output logic          host_rej,
    output logic [AW-1:0] a_addr1,
    output logic [AW-1:0] a_addr2,
    output logic          a_mwr,
    output logic [AW-1:0] b_addr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          c_wr,
    output logic [AW-1:0] c_addr,
    output logic          c_sel,
    output logic          busy,
    output logic          done
);

    localparam int LW = $clog2(N);
    localparam logic [LW-1:0] K_LAST     = LW'(N - 1);
    localparam logic [LW-1:0] I_LAST     = LW'(N - 2);
    localparam logic [1:0]    DRAIN_INIT = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WR0,
        S_WR1,
        S_FIN
    } state_t;

    state_t            state;
    logic [LW-1:0]     i_cnt;
    logic [LW-1:0]     j_cnt;
    logic [LW-1:0]     k_cnt;
    logic [1:0]        d_cnt;
    logic [RD_LAT-1:0] en_pipe;
    logic [RD_LAT-1:0] clr_pipe;
    logic [LW-1:0]     i_odd;
    logic              idle;

    assign idle  = (state == S_IDLE);
    // i is always even, so row i+1 is i with its low bit set
    assign i_odd = {i_cnt[LW-1:1], 1'b1};

    // RAM address muxing: host pass-through when idle, counters when busy
    always_comb begin
        a_addr1 = host_addr;
        a_addr2 = host_addr;
        b_addr  = '0;
        a_mwr   = host_wr & idle;
        if (!idle) begin
            a_addr1 = AW'({i_cnt, k_cnt});
            a_addr2 = AW'({i_odd, k_cnt});
            b_addr  = AW'({k_cnt, j_cnt});
        end
    end

    // Sequencer FSM with registered strobes and pair counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            i_cnt    <= '0;
            j_cnt    <= '0;
            k_cnt    <= '0;
            d_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            host_rej <= 1'b0;
            c_wr     <= 1'b0;
            c_sel    <= 1'b0;
            c_addr   <= '0;
        end else begin
            host_rej <= host_wr & ~idle;
            done     <= 1'b0;
            c_wr     <= 1'b0;
            c_sel    <= 1'b0;
            c_addr   <= '0;
            if (abort) begin
                state <= S_IDLE;
                i_cnt <= '0;
                j_cnt <= '0;
                k_cnt <= '0;
                d_cnt <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        // k stays at N-1 through DRAIN so the addresses hold
                        if (k_cnt == K_LAST) begin
                            state <= S_DRAIN;
                            d_cnt <= DRAIN_INIT;
                        end else begin
                            k_cnt <= k_cnt + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (d_cnt == 2'd0) begin
                            state  <= S_WR0;
                            c_wr   <= 1'b1;
                            c_sel  <= 1'b0;
                            c_addr <= AW'({i_cnt, j_cnt});
                        end else begin
                            d_cnt <= d_cnt - 1'b1;
                        end
                    end
                    S_WR0: begin
                        state  <= S_WR1;
                        c_wr   <= 1'b1;
                        c_sel  <= 1'b1;
                        c_addr <= AW'({i_odd, j_cnt});
                    end
                    S_WR1: begin
                        k_cnt <= '0;
                        if (i_cnt == I_LAST && j_cnt == K_LAST) begin
                            state <= S_FIN;
                        end else begin
                            state <= S_RUN;
                            if (j_cnt == K_LAST) begin
                                j_cnt <= '0;
                                i_cnt <= i_cnt + LW'(2);
                            end else begin
                                j_cnt <= j_cnt + 1'b1;
                            end
                        end
                    end
                    S_FIN: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        i_cnt <= '0;
                        j_cnt <= '0;
                        k_cnt <= '0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Read-latency delay line turning issue strobes into MAC enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_pipe  <= '0;
            clr_pipe <= '0;
        end else if (abort) begin
            en_pipe  <= '0;
            clr_pipe <= '0;
        end else begin
            en_pipe[0]  <= (state == S_RUN);
            clr_pipe[0] <= (state == S_RUN) && (k_cnt == '0);
            for (int s = 1; s < RD_LAT; s++) begin
                en_pipe[s]  <= en_pipe[s-1];
                clr_pipe[s] <= clr_pipe[s-1];
            end
        end
    end

    assign mac_en  = en_pipe[RD_LAT-1];
    assign mac_clr = clr_pipe[RD_LAT-1];

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: behavioural RAMs and MACs around the sequencer,
// idle-path vector table, then full runs, abort/restart and mid-run reset.
module tb_matmul_seq_ctrl;

    localparam int N  = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          host_wr = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic signed [7:0] host_data = '0;
    logic          host_rej;
    logic [AW-1:0] a_addr1, a_addr2, b_addr, c_addr;
    logic          a_mwr, mac_en, mac_clr, c_wr, c_sel, busy, done;

    int nchecks = 0;
    int nfail   = 0;

    matmul_seq_ctrl #(.N(N), .AW(AW), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .host_wr(host_wr), .host_addr(host_addr), .host_rej(host_rej),
        .a_addr1(a_addr1), .a_addr2(a_addr2), .a_mwr(a_mwr), .b_addr(b_addr),
        .mac_en(mac_en), .mac_clr(mac_clr), .c_wr(c_wr), .c_addr(c_addr),
        .c_sel(c_sel), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // external memories and accumulators
    logic signed [7:0]  ram_a [64];
    logic signed [7:0]  ram_b [64];
    logic signed [31:0] ram_c [64];
    logic signed [7:0]  exp_a [64];
    logic signed [7:0]  a_q1, a_q2, b_q;
    logic signed [31:0] acc0 = 0, acc1 = 0;

    always @(posedge clk) begin
        if (a_mwr) ram_a[a_addr1] <= host_data;
        a_q1 <= ram_a[a_addr1];
        a_q2 <= ram_a[a_addr2];
        b_q  <= ram_b[b_addr];
        if (mac_en) begin
            acc0 <= (mac_clr ? 32'sd0 : acc0) + 32'(a_q1) * 32'(b_q);
            acc1 <= (mac_clr ? 32'sd0 : acc1) + 32'(a_q2) * 32'(b_q);
        end
        if (c_wr) ram_c[c_addr] <= c_sel ? acc1 : acc0;
    end

    task automatic check(input string nm, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // run statistics
    int n_wr, post_wr, done_cyc, done_cnt, mac_cnt, clr_cnt, sel_err;
    int addr_log [64];
    int wr_per_addr [64];

    task automatic load_a(input int mode, input int skip0);
        for (int a = 0; a < 64; a++) begin
            logic signed [7:0] v;
            if (mode == 0) v = ((a / N) == (a % N)) ? 8'sd1 : 8'sd0;
            else           v = -8'sd128;
            exp_a[a] = v;
            if (!(skip0 != 0 && a == 0)) begin
                @(negedge clk);
                host_wr = 1'b1; host_addr = AW'(a); host_data = v;
            end
        end
        @(negedge clk);
        host_wr = 1'b0;
    endtask

    task automatic do_run(input int abort_at, input int inj_at,
                          input logic with_host, input logic signed [7:0] hval);
        n_wr = 0; post_wr = 0; done_cyc = -1; done_cnt = 0;
        mac_cnt = 0; clr_cnt = 0; sel_err = 0;
        for (int a = 0; a < 64; a++) begin addr_log[a] = -1; wr_per_addr[a] = 0; end
        @(negedge clk);
        start = 1'b1;
        if (with_host) begin host_wr = 1'b1; host_addr = '0; host_data = hval; end
        @(posedge clk); #1;
        start = 1'b0; host_wr = 1'b0;
        check("busy_after_start", busy, 1);
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            @(posedge clk); #1;
            if (cyc == abort_at + 1) begin
                abort = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_mac_en", mac_en, 0);
                check("abort_c_wr", c_wr, 0);
            end
            if (c_wr) begin
                if (n_wr < 64) addr_log[n_wr] = int'(c_addr);
                if (c_sel != n_wr[0]) sel_err++;
                wr_per_addr[c_addr]++;
                n_wr++;
                if (abort_at > 0 && cyc > abort_at) post_wr++;
            end
            mac_cnt += int'(mac_en);
            clr_cnt += int'(mac_en & mac_clr);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check("busy_at_done", busy, 0);
                end
            end
            if (cyc == inj_at) begin
                host_wr = 1'b1; host_addr = 6'd5; host_data = 8'sd99;
                #1;
                check("busy_a_mwr", a_mwr, 0);
            end
            if (cyc == inj_at + 1) begin
                check("host_rej_set", host_rej, 1);
                host_wr = 1'b0;
            end
            if (cyc == inj_at + 2) check("host_rej_clear", host_rej, 0);
            if (cyc == abort_at) abort = 1'b1;
            if (done_cyc >= 0 && cyc > done_cyc + 2) break;
            if (abort_at > 0 && cyc > abort_at + 40) break;
        end
        if (abort_at <= 0 && done_cyc < 0) check("run_timeout", 0, 1);
    endtask

    task automatic check_c(input string nm);
        int bad = 0;
        int multi = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                int e = 0;
                for (int k = 0; k < N; k++) e += int'(exp_a[r*N+k]) * int'(ram_b[k*N+c]);
                if (ram_c[r*N+c] !== e) begin
                    if (bad == 0)
                        $display("FAIL %s_entry r=%0d c=%0d actual=%0d required=%0d",
                                 nm, r, c, ram_c[r*N+c], e);
                    bad++;
                end
                if (wr_per_addr[r*N+c] != 1) multi++;
            end
        check({nm, "_mismatches"}, bad, 0);
        check({nm, "_addr_not_once"}, multi, 0);
    endtask

    task automatic check_full_run(input string nm);
        check({nm, "_c_wr_count"}, n_wr, 64);
        check({nm, "_done_cycle"}, done_cyc, 353);
        check({nm, "_done_pulses"}, done_cnt, 1);
        check({nm, "_mac_en_count"}, mac_cnt, 256);
        check({nm, "_mac_clr_count"}, clr_cnt, 32);
        check({nm, "_sel_alternation_errors"}, sel_err, 0);
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic          st;
        logic          ab;
        logic          exp_mwr;
        logic          exp_busy;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{1'b1, 6'd5,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 6'd63, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 6'd42, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 6'd17, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int a = 0; a < 64; a++) ram_b[a] = 8'(a);

        // reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_c_wr", c_wr, 0);
        check("rst_host_rej", host_rej, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // idle pass-through and start/abort priority
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            host_wr = vecs[v].wr; host_addr = vecs[v].addr; host_data = '0;
            start = vecs[v].st; abort = vecs[v].ab;
            #1;
            check($sformatf("vec%0d_a_addr1", v), a_addr1, vecs[v].addr);
            check($sformatf("vec%0d_a_addr2", v), a_addr2, vecs[v].addr);
            check($sformatf("vec%0d_a_mwr", v), a_mwr, vecs[v].exp_mwr);
            check($sformatf("vec%0d_b_addr", v), b_addr, 0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
            check($sformatf("vec%0d_host_rej", v), host_rej, 0);
            check($sformatf("vec%0d_c_wr", v), c_wr, 0);
        end
        @(negedge clk);
        host_wr = 1'b0; start = 1'b0; abort = 1'b0;

        // A = identity (A[0] written in the start cycle), B[r][c] = r*8+c
        load_a(0, 1);
        exp_a[0] = 8'sd1;
        do_run(-1, 20, 1'b1, 8'sd1);
        check_full_run("ident");
        check("order_0", addr_log[0], 0);
        check("order_1", addr_log[1], 8);
        check("order_2", addr_log[2], 1);
        check("order_3", addr_log[3], 9);
        check("order_62", addr_log[62], 55);
        check("order_63", addr_log[63], 63);
        check("ram_a5_unchanged", ram_a[5], 0);
        check_c("ident");

        // all -128 operands: 8*16384 per entry
        for (int a = 0; a < 64; a++) ram_b[a] = -8'sd128;
        load_a(1, 0);
        do_run(-1, -10, 1'b0, 8'sd0);
        check_full_run("neg");
        check_c("neg");
        check("neg_entry_value", ram_c[27], 131072);

        // abort mid-run, then restart
        do_run(100, -10, 1'b0, 8'sd0);
        check("abort_post_c_wr", post_wr, 0);
        check("abort_no_done", done_cnt, 0);
        check("abort_partial_writes", n_wr > 0 && n_wr < 64, 1);
        do_run(-1, -10, 1'b0, 8'sd0);
        check_full_run("restart");
        check_c("restart");

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_mac_en", mac_en, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_c_wr", c_wr, 0);
        check("midrst_mac_en", mac_en, 0);
        check("midrst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int dn = 0;
            int wr = 0;
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(posedge clk); #1;
                dn += int'(done);
                wr += int'(c_wr);
            end
            check("midrst_no_done", dn, 0);
            check("midrst_no_c_wr", wr, 0);
            check("midrst_idle", busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
